// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the basic CPU (sequencer, counter,
// ALU, memory).
//   opcode_t : 3-bit instruction opcode
//   phase_t  : 3-bit sequencer phase, INST_ADDR=0 .. STORE=7
//   PHASES   : number of sequencer phases
package cpu_pkg;

   localparam int unsigned PHASES = 8;

   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   // Opcodes that read an operand from memory into the accumulator.
   function automatic logic is_aluop(input opcode_t op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/control_phase_seq.sv
// phase_seq: 3-bit sequencer phase register.
//   clk_i    : rising-edge clock
//   rst_i    : asynchronous active-high reset, phase -> INST_ADDR
//   en_i     : advance enable
//   freeze_i : hold the phase regardless of en_i (halt)
//   phase_o  : registered phase (cpu_pkg::phase_t encoding)
module phase_seq
   import cpu_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       freeze_i,
   output logic [2:0] phase_o
);

   phase_t phase_q, phase_d;

   // STORE + 1 wraps naturally to INST_ADDR in 3 bits.
   always_comb begin
      phase_d = phase_q;
      if (en_i && !freeze_i)
         phase_d = phase_t'(phase_q + 3'd1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         phase_q <= INST_ADDR;
      else
         phase_q <= phase_d;
   end

   assign phase_o = phase_q;

endmodule

// File: rtl/control.sv
// control: eight-phase instruction sequencer for the basic CPU.
//   clk         : rising-edge clock
//   rst_        : asynchronous active-high reset
//   en          : phase advance enable (low holds the phase)
//   opcode      : IR opcode field (cpu_pkg::opcode_t)
//   zero        : accumulator-is-zero flag
//   sel         : address mux select, 1 = PC, 0 = IR address field
//   mem_rd      : memory read strobe
//   mem_wr      : memory write strobe
//   load_ir     : instruction register load
//   load_ac     : accumulator load
//   inc_pc      : PC increment (counter enable)
//   load_pc     : PC load (counter load)
//   halt        : sticky halted indication
//   instr_count : retired instruction count, CNT_W bits
// Build option: CTRL_INSTR_CNT_EN adds CNT_W and the instr_count port/counter.
module control
   import cpu_pkg::*;
`ifdef CTRL_INSTR_CNT_EN
#(
   parameter int unsigned CNT_W = 16
)
`endif
(
   input  logic             clk,
   input  logic             rst_,
   input  logic             en,
   input  logic [2:0]       opcode,
   input  logic             zero,
   output logic             sel,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             load_ir,
   output logic             load_ac,
   output logic             inc_pc,
   output logic             load_pc,
   output logic             halt
`ifdef CTRL_INSTR_CNT_EN
   ,
   output logic [CNT_W-1:0] instr_count
`endif
);

   opcode_t    op;
   phase_t     phase;
   logic [2:0] phase_raw;
   logic       halt_q, halt_d;
   logic       set_halt;
   logic       aluop;

   assign op    = opcode_t'(opcode);
   assign phase = phase_t'(phase_raw);
   assign aluop = is_aluop(op);

   // Freezing on the setting edge keeps the phase parked at OP_ADDR.
   always_comb begin
      set_halt = (phase == OP_ADDR) && (op == OP_HLT) && en && !halt_q;
      halt_d   = halt_q | set_halt;
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_)
         halt_q <= 1'b0;
      else
         halt_q <= halt_d;
   end

   phase_seq u_seq (
      .clk_i    (clk),
      .rst_i    (rst_),
      .en_i     (en),
      .freeze_i (halt_q | set_halt),
      .phase_o  (phase_raw)
   );

   always_comb begin
      sel     = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      load_ir = 1'b0;
      load_ac = 1'b0;
      inc_pc  = 1'b0;
      load_pc = 1'b0;
      if (!halt_q) begin
         case (phase)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
               sel    = 1'b1;
               mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel     = 1'b1;
               mem_rd  = 1'b1;
               load_ir = 1'b1;
            end
            OP_ADDR:  inc_pc = (op != OP_HLT);
            OP_FETCH: mem_rd = aluop;
            ALU_OP: begin
               mem_rd = aluop;
               inc_pc = (op == OP_SKZ) && zero;
            end
            STORE: begin
               mem_rd  = aluop;
               load_ac = aluop;
               mem_wr  = (op == OP_STO);
               load_pc = (op == OP_JMP);
            end
            default: ;
         endcase
      end
   end

   assign halt = halt_q;

`ifdef CTRL_INSTR_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Retire on the STORE -> INST_ADDR edge; a halted sequencer never gets here.
   always_comb begin
      cnt_d = cnt_q;
      if ((phase == STORE) && en && !halt_q)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_control.sv
module tb_control;
   import cpu_pkg::*;

   logic       clk, rst_, en, zero;
   logic [2:0] opcode;
   logic       sel, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt;
`ifdef CTRL_INSTR_CNT_EN
   logic [15:0] instr_count;
   logic [2:0]  w_count;
   logic        w_sel, w_rd, w_wr, w_ir, w_ac, w_inc, w_ld, w_halt;
`endif

   int total = 0;
   int bad   = 0;

   control dut (
      .clk(clk), .rst_(rst_), .en(en), .opcode(opcode), .zero(zero),
      .sel(sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir),
      .load_ac(load_ac), .inc_pc(inc_pc), .load_pc(load_pc), .halt(halt)
`ifdef CTRL_INSTR_CNT_EN
      , .instr_count(instr_count)
`endif
   );

`ifdef CTRL_INSTR_CNT_EN
   // Narrow counter instance so the wrap is reachable in a short run.
   control #(.CNT_W(3)) dut_w (
      .clk(clk), .rst_(rst_), .en(en), .opcode(opcode), .zero(zero),
      .sel(w_sel), .mem_rd(w_rd), .mem_wr(w_wr), .load_ir(w_ir),
      .load_ac(w_ac), .inc_pc(w_inc), .load_pc(w_ld), .halt(w_halt),
      .instr_count(w_count)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {sel, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt}
   function automatic logic [7:0] strobes();
      return {sel, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt};
   endfunction

   typedef struct {
      logic [2:0] op;
      logic       z;
      logic [2:0] ph;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Fetch half is opcode-independent; fop lets a row drive a different
   // (don't-care) opcode during the fetch phases.
   task automatic push_instr(input logic [2:0] fop, input logic [2:0] op, input logic z,
                             input logic [7:0] e4, input logic [7:0] e5,
                             input logic [7:0] e6, input logic [7:0] e7);
      vecs.push_back('{fop, z, 3'd0, 8'h80});
      vecs.push_back('{fop, z, 3'd1, 8'hC0});
      vecs.push_back('{fop, z, 3'd2, 8'hD0});
      vecs.push_back('{fop, z, 3'd3, 8'hD0});
      vecs.push_back('{op,  z, 3'd4, e4});
      vecs.push_back('{op,  z, 3'd5, e5});
      vecs.push_back('{op,  z, 3'd6, e6});
      vecs.push_back('{op,  z, 3'd7, e7});
   endtask

   task automatic do_reset();
      rst_ = 1'b1;
      @(negedge clk);
      rst_ = 1'b0;
   endtask

   initial begin
      rst_ = 1'b1; en = 1'b1; opcode = 3'd2; zero = 1'b0;

      push_instr(3'd2, 3'd2, 1'b0, 8'h04, 8'h40, 8'h40, 8'h48); // ADD
      push_instr(3'd1, 3'd1, 1'b1, 8'h04, 8'h00, 8'h04, 8'h00); // SKZ, zero=1
      push_instr(3'd1, 3'd1, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00); // SKZ, zero=0
      push_instr(3'd0, 3'd7, 1'b1, 8'h04, 8'h00, 8'h00, 8'h02); // JMP, HLT in fetch
      push_instr(3'd6, 3'd6, 1'b0, 8'h04, 8'h00, 8'h00, 8'h20); // STO
      push_instr(3'd3, 3'd3, 1'b1, 8'h04, 8'h40, 8'h40, 8'h48); // AND, zero=1

      @(negedge clk);
      check("reset_phase", 16'(dut.phase), 16'd0);
      check("reset_strobes", 16'(strobes()), 16'h0080);
`ifdef CTRL_INSTR_CNT_EN
      check("reset_count", instr_count, 16'd0);
`endif
      rst_ = 1'b0;

      foreach (vecs[i]) begin
         opcode = vecs[i].op;
         zero   = vecs[i].z;
         #1;
         check($sformatf("vec%0d_phase", i), 16'(dut.phase), 16'(vecs[i].ph));
         check($sformatf("vec%0d_strobes", i), 16'(strobes()), 16'(vecs[i].exp));
         @(negedge clk);
      end
`ifdef CTRL_INSTR_CNT_EN
      check("count_after_table", instr_count, 16'd6);
`endif

      // en low for 3 cycles in INST_FETCH
      do_reset();
      opcode = 3'd2; zero = 1'b0;
      @(negedge clk);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_phase", 16'(dut.phase), 16'd1);
         check("hold_strobes", 16'(strobes()), 16'h00C0);
      end
      en = 1'b1;
      @(negedge clk);
      check("resume_phase", 16'(dut.phase), 16'd2);
      check("resume_strobes", 16'(strobes()), 16'h00D0);

      // async reset in the middle of ALU_OP of a STO
      do_reset();
      opcode = 3'd6;
      repeat (6) @(negedge clk);
      #1;
      check("pre_abort_phase", 16'(dut.phase), 16'd6);
      check("pre_abort_strobes", 16'(strobes()), 16'h0000);
      #2 rst_ = 1'b1;
      #1;
      check("abort_phase", 16'(dut.phase), 16'd0);
      check("abort_strobes", 16'(strobes()), 16'h0080);
      @(negedge clk);
      check("abort_hold_strobes", 16'(strobes()), 16'h0080);
      rst_ = 1'b0;

      // HLT at OP_ADDR
      opcode = 3'd0;
      repeat (4) @(negedge clk);
      check("hlt_opaddr_phase", 16'(dut.phase), 16'd4);
      check("hlt_opaddr_strobes", 16'(strobes()), 16'h0000);
      @(negedge clk);
      check("halt_set_strobes", 16'(strobes()), 16'h0001);
      opcode = 3'd2;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halted_phase", 16'(dut.phase), 16'd4);
         check("halted_strobes", 16'(strobes()), 16'h0001);
      end
`ifdef CTRL_INSTR_CNT_EN
      check("halt_no_retire", instr_count, 16'd0);
`endif
      rst_ = 1'b1;
      #1;
      check("unhalt_phase", 16'(dut.phase), 16'd0);
      check("unhalt_strobes", 16'(strobes()), 16'h0080);
      @(negedge clk);
      rst_ = 1'b0;

`ifdef CTRL_INSTR_CNT_EN
      opcode = 3'd2;
      repeat (40) @(negedge clk);
      check("count_5", instr_count, 16'd5);
      check("wcount_5", 16'(w_count), 16'd5);
      repeat (16) @(negedge clk);
      check("wcount_7", 16'(w_count), 16'd7);
      repeat (8) @(negedge clk);
      check("count_8", instr_count, 16'd8);
      check("wcount_wrap", 16'(w_count), 16'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
